// File: rtl/imm_encoder_component.sv
// imm_encoder_component: packs a requested immediate into one of several
// instruction formats; unencodable requests are dropped and counted.
`default_nettype none

module imm_encoder_component (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  opcode,
    input  logic [15:0] value,
    input  logic [7:0]  fields,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] inst,
    output logic        err,
    output logic [7:0]  err_count
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [3:0] OP_HI8   = 4'b0101;
    localparam logic [3:0] OP_HALF  = 4'b0110;
    localparam logic [3:0] OP_LO4_A = 4'b1000;
    localparam logic [3:0] OP_LO4_B = 4'b1001;
    localparam logic [3:0] OP_LO4_C = 4'b1010;
    localparam logic [3:0] OP_U8    = 4'b1111;

    state_t      state_q;
    state_t      state_d;
    logic        encodable;
    logic [15:0] encoded;
    logic        accept;
    logic        consume;
    logic        load;
    logic        err_d;

    // Each format only succeeds if the decoder would rebuild exactly 'value'.
    always_comb begin
        encodable = 1'b0;
        encoded   = 16'h0000;
        case (opcode)
            OP_HI8: begin
                encodable = (value[7:0] == 8'h00);
                encoded   = {value[15:8], fields[3:0], OP_HI8};
            end
            OP_HALF: begin
                encodable = !value[0] && (value[15:9] == {7{value[8]}});
                encoded   = {value[8:1], fields[3:0], OP_HALF};
            end
            OP_LO4_A, OP_LO4_B, OP_LO4_C: begin
                encodable = (value[15:4] == {12{value[3]}});
                encoded   = {fields, value[3:0], opcode};
            end
            OP_U8: begin
                encodable = (value[15:8] == 8'h00);
                encoded   = {value[7:0], fields[3:0], OP_U8};
            end
            default: begin
                encodable = 1'b0;
                encoded   = 16'h0000;
            end
        endcase
    end

    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    // A rejected accept while FULL implies a concurrent consume, so it empties.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        err_d   = 1'b0;
        if (accept && encodable) begin
            load    = 1'b1;
            state_d = FULL;
        end else if (consume) begin
            state_d = EMPTY;
        end
        if (accept && !encodable) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= EMPTY;
            inst      <= 16'h0000;
            err       <= 1'b0;
            err_count <= 8'h00;
        end else begin
            state_q <= state_d;
            err     <= err_d;
            if (load) begin
                inst <= encoded;
            end
            if (err_d && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder_component.sv
// Directed self-checking bench for imm_encoder_component.
`default_nettype none

module tb_imm_encoder_component;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [15:0] value;
    logic [7:0]  fields;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] inst;
    logic        err;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;

    imm_encoder_component dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .value     (value),
        .fields    (fields),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst      (inst),
        .err       (err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One-cycle request; outputs are sampled 1 time unit after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [15:0] val, input logic [7:0] fld);
        @(negedge clk);
        opcode   = op;
        value    = val;
        fields   = fld;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] val;
        logic [7:0]  fld;
        logic        ok;
        logic [15:0] exp_inst;
    } vec_t;

    vec_t vecs[$];
    int   exp_cnt;

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        opcode    = 4'h0;
        value     = 16'h0000;
        fields    = 8'h00;
        exp_cnt   = 0;

        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_inst",      32'(inst),      32'h0000);
        check("rst_err",       32'(err),       32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        vecs.push_back('{4'b0101, 16'h1200, 8'h03, 1'b1, 16'h1235});
        vecs.push_back('{4'b0110, 16'hFFFC, 8'h02, 1'b1, 16'hFE26});
        vecs.push_back('{4'b0110, 16'h0101, 8'h00, 1'b0, 16'h0000});
        vecs.push_back('{4'b1000, 16'hFFF9, 8'hAB, 1'b1, 16'hAB98});
        vecs.push_back('{4'b1111, 16'h0100, 8'h00, 1'b0, 16'h0000});
        vecs.push_back('{4'b1010, 16'h0007, 8'h12, 1'b1, 16'h127A});
        vecs.push_back('{4'b1001, 16'hFFF7, 8'h00, 1'b0, 16'h0000});
        vecs.push_back('{4'b1001, 16'hFFF8, 8'hC4, 1'b1, 16'hC489});
        vecs.push_back('{4'b0101, 16'h1201, 8'h03, 1'b0, 16'h0000});
        vecs.push_back('{4'b1111, 16'h00FF, 8'h00, 1'b1, 16'hFF0F});
        vecs.push_back('{4'b0110, 16'h00FE, 8'h00, 1'b1, 16'h7F06});
        vecs.push_back('{4'b0110, 16'h0100, 8'h00, 1'b0, 16'h0000});
        vecs.push_back('{4'b0011, 16'h0000, 8'h00, 1'b0, 16'h0000});

        // Back-to-back requests with out_ready=1: each word is consumed as the next arrives.
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].val, vecs[i].fld);
            if (!vecs[i].ok && exp_cnt < 255) exp_cnt++;
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ok));
            check($sformatf("v%0d_err", i),       32'(err),       32'(!vecs[i].ok));
            check($sformatf("v%0d_err_count", i), 32'(err_count), 32'(exp_cnt));
            if (vecs[i].ok) check($sformatf("v%0d_inst", i), 32'(inst), 32'(vecs[i].exp_inst));
        end
        @(posedge clk);
        #1;
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("err_one_cycle",   32'(err),       32'd0);

        // Backpressure: first word held, second request waits, then loads with no bubble.
        out_ready = 1'b0;
        send(4'b0101, 16'h1200, 8'h03);
        check("bp_first_inst", 32'(inst), 32'h1235);
        opcode   = 4'b1000;
        value    = 16'h0003;
        fields   = 8'h55;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold%0d_inst", c),      32'(inst),      32'h1235);
            check($sformatf("bp_hold%0d_valid", c),     32'(out_valid), 32'd1);
            check($sformatf("bp_hold%0d_in_ready", c),  32'(in_ready),  32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_comb", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_second_inst",  32'(inst),      32'h5538);
        check("bp_second_valid", 32'(out_valid), 32'd1);

        // Asynchronous reset mid-cycle while FULL and stalled.
        out_ready = 1'b0;
        send(4'b0101, 16'h1200, 8'h03);
        check("ar_pre_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_inst",      32'(inst),      32'h0000);
        check("ar_err_count", 32'(err_count), 32'd0);
        check("ar_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;

        // Saturating error counter.
        @(negedge clk);
        opcode   = 4'b0000;
        value    = 16'h0000;
        in_valid = 1'b1;
        repeat (255) @(posedge clk);
        #1;
        check("sat_255",     32'(err_count), 32'd255);
        check("sat_err",     32'(err),       32'd1);
        @(posedge clk);
        #1;
        check("sat_256",     32'(err_count), 32'd255);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("sat_257",     32'(err_count), 32'd255);
        check("sat_no_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imm_encoder_component.md
IMM_ENCODER_COMPONENT -- requirements
Module: imm_encoder_component

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising edge), reset input 1 (0 = reset, asynchronous assert).
REQ-002 in_valid  input  1  request carries opcode/value/fields this cycle.
REQ-003 in_ready  output 1  block can accept a request this cycle.
REQ-004 opcode  input  4  target instruction opcode, placed in inst[3:0].
REQ-005 value  input  16  desired sign/zero-interpreted immediate, two's complement.
REQ-006 fields  input  8  non-immediate instruction fields.
REQ-007 out_valid  output 1  inst holds an encoded instruction.
REQ-008 out_ready  input  1  consumer takes inst this cycle.
REQ-009 inst  output 16  encoded instruction word.
REQ-010 err  output 1  one-cycle pulse: last accepted request was not encodable.
REQ-011 err_count  output 8  count of rejected requests, saturating.

Function
REQ-012 Transfer in: request accepted on a rising clk edge where in_valid && in_ready.
REQ-013 Transfer out: instruction consumed on a rising clk edge where out_valid && out_ready.
REQ-014 in_ready SHALL equal !out_valid || out_ready (single output register, combinational path from out_ready only).
REQ-015 States: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on encodable accept; FULL->EMPTY on consume without encodable accept; FULL->FULL on simultaneous consume and encodable accept (new word loaded, no bubble).
REQ-016 Latency: encodable request accepted at edge N -> out_valid=1 with inst valid after edge N.
REQ-017 While FULL and out_ready=0, inst and out_valid SHALL be held stable.
REQ-018 Opcode 0101: encodable iff value[7:0]==0; inst = {value[15:8], fields[3:0], 0101}.
REQ-019 Opcode 0110: encodable iff value[0]==0 and value[15:9] all equal value[8]; inst = {value[8:1], fields[3:0], 0110}.
REQ-020 Opcodes 1000/1001/1010: encodable iff value[15:4] all equal value[3]; inst = {fields[7:0], value[3:0], opcode}.
REQ-021 Opcode 1111: encodable iff value[15:8]==0; inst = {value[7:0], fields[3:0], 1111}.
REQ-022 Any other opcode SHALL be non-encodable.
REQ-023 Non-encodable accepted request: no instruction loaded; err=1 for exactly the cycle after the accepting edge; err_count increments by 1, saturating at 255.
REQ-024 Non-encodable accept while FULL with simultaneous consume SHALL leave block EMPTY; without consume it cannot occur (in_ready=0).
REQ-025 Round trip: for every encoded inst, the decoder immediate of inst SHALL equal value.

Reset
REQ-026 reset=0 SHALL immediately force out_valid=0, inst=0x0000, err=0, err_count=0, state EMPTY, regardless of clk, including mid-hold.
REQ-027 First accept possible on first rising clk edge after reset deasserts; in_ready=1 during and after reset.

Verification
REQ-028 opcode 0101, value 0x1200, fields 0x03 -> next cycle out_valid=1, inst=0x1235, err=0.
REQ-029 opcode 0110, value 0xFFFC, fields 0x02 -> inst=0xFE26; value 0x0101 -> err pulse, err_count +1, out_valid stays 0.
REQ-030 opcode 1000, value 0xFFF9, fields 0xAB -> inst=0xAB98; opcode 1111, value 0x0100 -> err=1, err_count=1, no out_valid.
REQ-031 Backpressure: encode 0x1235, hold out_ready=0 for 3 cycles with second request pending -> inst stable, in_ready=0, second not accepted; out_ready=1 -> second loaded same edge, no bubble.
REQ-032 256 consecutive non-encodable requests (opcode 0000) -> err_count=255 and stays 255 on the 257th.
REQ-033 Assert reset=0 mid-cycle while FULL with out_ready=0 -> out_valid=0, inst=0x0000, err_count=0 immediately, before next clk edge.
